// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment driver with frame-aligned double buffering.
// Optional leading-zero blanking is enabled by defining SEVSEG_LZ_BLANK_EN.
module seven_seg_scan #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int unsigned PRESC_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [1:0]         idx_q, idx_d;
    logic [15:0]        pend_dig_q, pend_dig_d;
    logic [3:0]         pend_dp_q, pend_dp_d;
    logic [15:0]        disp_dig_q, disp_dig_d;
    logic [3:0]         disp_dp_q, disp_dp_d;
    logic               boundary_q, boundary_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic               frame_tick_q, frame_tick_d;

    logic               step;
    logic [3:0]         cur_nib;
    logic               blank_cur;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b0111111;
        endcase
    endfunction

    // NOTE: every variable gets a default at the top of the block so no latch is inferred.
    always_comb begin
        step         = (presc_q == PRESC_MAX);
        presc_d      = step ? '0 : presc_q + PRESC_W'(1);
        idx_d        = step ? idx_q + 2'd1 : idx_q;
        boundary_d   = step && (idx_q == 2'd3);

        pend_dig_d   = pend_dig_q;
        pend_dp_d    = pend_dp_q;
        disp_dig_d   = disp_dig_q;
        disp_dp_d    = disp_dp_q;

        if (load) begin
            pend_dig_d = digits_in;
            pend_dp_d  = dp_in;
        end

        // A load landing on the boundary bypasses pending so it is not a frame late.
        if (boundary_d) begin
            disp_dig_d = load ? digits_in : pend_dig_q;
            disp_dp_d  = load ? dp_in     : pend_dp_q;
        end
    end

    always_comb begin
        cur_nib   = disp_dig_q[{idx_q, 2'b00} +: 4];
        blank_cur = 1'b0;
`ifdef SEVSEG_LZ_BLANK_EN
        case (idx_q)
            2'd3:    blank_cur = (disp_dig_q[15:12] == 4'd0);
            2'd2:    blank_cur = (disp_dig_q[15:8]  == 8'd0);
            2'd1:    blank_cur = (disp_dig_q[15:4]  == 12'd0);
            default: blank_cur = 1'b0;
        endcase
`else
        blank_cur = 1'b0;
`endif
        an_d         = ~(4'b0001 << idx_q);
        seg_d        = blank_cur ? 7'b1111111 : seg_decode(cur_nib);
        dp_d         = ~disp_dp_q[idx_q];
        frame_tick_d = boundary_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: the buffers are ordinary flops, so reset clears them and any pending value is lost.
    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            presc_q      <= '0;
            idx_q        <= 2'd0;
            pend_dig_q   <= 16'h0000;
            pend_dp_q    <= 4'b0000;
            disp_dig_q   <= 16'h0000;
            disp_dp_q    <= 4'b0000;
            boundary_q   <= 1'b0;
            an_q         <= 4'b1111;
            seg_q        <= 7'b1111111;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_dig_q   <= pend_dig_d;
            pend_dp_q    <= pend_dp_d;
            disp_dig_q   <= disp_dig_d;
            disp_dp_q    <= disp_dp_d;
            boundary_q   <= boundary_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with REFRESH_DIV = 4 (16-cycle frames).
// Expected outputs follow SEVSEG_LZ_BLANK_EN when the bench is built with it.
module tb_seven_seg_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic        load = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int checks = 0;
    int failures = 0;
    int cyc;

    seven_seg_scan #(.REFRESH_DIV(4)) dut (
        .clock_100Mhz(clk),
        .reset       (reset),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .load        (load),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; the DUT's prescaler and index advance in lockstep.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int i);
`ifdef SEVSEG_LZ_BLANK_EN
        if (i == 3 && v[15:12] == 4'd0)  return 7'b1111111;
        if (i == 2 && v[15:8]  == 8'd0)  return 7'b1111111;
        if (i == 1 && v[15:4]  == 12'd0) return 7'b1111111;
`endif
        return dec(v[i*4 +: 4]);
    endfunction

    // Expected {an, seg, dp, frame_tick} sampled after edge n while value v is displayed.
    function automatic logic [12:0] exp_out(input logic [15:0] v, input logic [3:0] dpv, input int n);
        int         oi;
        logic [3:0] a;
        oi = ((n - 1) / 4) % 4;
        a  = ~(4'b0001 << oi);
        return {a, exp_seg(v, oi), ~dpv[oi], (n % 16 == 1) && (n >= 17)};
    endfunction

    task automatic wait_phase(input int ph);
        for (int k = 0; k < 40; k++) begin
            if (cyc % 16 == ph) return;
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL wait_phase timeout: cyc=%0d never reached phase %0d", cyc, ph);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp, frame_tick} !== 13'b1111_1111111_1_0) begin
                failures++;
                $display("FAIL reset_hold k=%0d got an=%b seg=%b dp=%b ft=%b want 1111/1111111/1/0",
                         k, an, seg, dp, frame_tick);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({an, seg, dp, frame_tick} !== 13'b1110_1000000_1_0) begin
            failures++;
            $display("FAIL reset_release got an=%b seg=%b dp=%b ft=%b want 1110/1000000/1/0",
                     an, seg, dp, frame_tick);
        end
    endtask

    task automatic test_scan();
        logic [12:0] e;
        int          ticks;
        load = 1'b1; digits_in = 16'h1234; dp_in = 4'b0100;
        @(negedge clk);
        load = 1'b0;
        wait_phase(1);
        ticks = 0;
        for (int k = 0; k < 16; k++) begin
            e = exp_out(16'h1234, 4'b0100, cyc);
            ticks += int'(frame_tick);
            checks++;
            if ({an, seg, dp, frame_tick} !== e) begin
                failures++;
                $display("FAIL scan n=%0d got %b_%b_%b_%b want %b", cyc, an, seg, dp, frame_tick, e);
            end
            @(negedge clk);
        end
        checks++;
        if (ticks !== 1) begin
            failures++;
            $display("FAIL scan_tick_count got %0d want 1", ticks);
        end
    endtask

    task automatic test_no_tearing();
        logic [12:0] e;
        for (int k = 0; k < 32; k++) begin
            e = (k < 16) ? exp_out(16'h1234, 4'b0100, cyc) : exp_out(16'h5678, 4'b0000, cyc);
            checks++;
            if ({an, seg, dp, frame_tick} !== e) begin
                failures++;
                $display("FAIL no_tearing n=%0d got %b_%b_%b_%b want %b", cyc, an, seg, dp, frame_tick, e);
            end
            load = 1'b0;
            if (k == 4) begin load = 1'b1; digits_in = 16'h5678; dp_in = 4'b0000; end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] e;
        for (int k = 0; k < 32; k++) begin
            e = (k < 16) ? exp_out(16'h5678, 4'b0000, cyc) : exp_out(16'h2222, 4'b0000, cyc);
            checks++;
            if ({an, seg, dp, frame_tick} !== e) begin
                failures++;
                $display("FAIL back_to_back n=%0d got %b_%b_%b_%b want %b", cyc, an, seg, dp, frame_tick, e);
            end
            load = 1'b0;
            if (k == 2) begin load = 1'b1; digits_in = 16'h1111; dp_in = 4'b0000; end
            if (k == 7) begin load = 1'b1; digits_in = 16'h2222; dp_in = 4'b0000; end
            @(negedge clk);
        end
    endtask

    task automatic test_coincident();
        logic [12:0] e;
        for (int k = 0; k < 32; k++) begin
            e = (k < 16) ? exp_out(16'h2222, 4'b0000, cyc) : exp_out(16'h9999, 4'b1111, cyc);
            checks++;
            if ({an, seg, dp, frame_tick} !== e) begin
                failures++;
                $display("FAIL coincident n=%0d got %b_%b_%b_%b want %b", cyc, an, seg, dp, frame_tick, e);
            end
            load = 1'b0;
            if (k == 14) begin load = 1'b1; digits_in = 16'h9999; dp_in = 4'b1111; end
            @(negedge clk);
        end
    endtask

    task automatic test_invalid();
        logic [12:0] e;
        for (int k = 0; k < 32; k++) begin
            e = (k < 16) ? exp_out(16'h9999, 4'b1111, cyc) : exp_out(16'h00A0, 4'b0001, cyc);
            checks++;
            if ({an, seg, dp, frame_tick} !== e) begin
                failures++;
                $display("FAIL invalid n=%0d got %b_%b_%b_%b want %b", cyc, an, seg, dp, frame_tick, e);
            end
            load = 1'b0;
            if (k == 0) begin load = 1'b1; digits_in = 16'h00A0; dp_in = 4'b0001; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] e;
        for (int k = 0; k < 25; k++) begin
            e = (k < 16) ? exp_out(16'h00A0, 4'b0001, cyc) : exp_out(16'h1234, 4'b0100, cyc);
            checks++;
            if ({an, seg, dp, frame_tick} !== e) begin
                failures++;
                $display("FAIL reset_mid_pre n=%0d got %b_%b_%b_%b want %b", cyc, an, seg, dp, frame_tick, e);
            end
            load = 1'b0;
            if (k == 0) begin load = 1'b1; digits_in = 16'h1234; dp_in = 4'b0100; end
            @(negedge clk);
        end
        checks++;
        if ({an, seg, dp} !== 12'b1011_0100100_0) begin
            failures++;
            $display("FAIL reset_mid_digit2 got an=%b seg=%b dp=%b want 1011/0100100/0", an, seg, dp);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({an, seg, dp, frame_tick} !== 13'b1111_1111111_1_0) begin
            failures++;
            $display("FAIL reset_mid_async got %b_%b_%b_%b want 1111_1111111_1_0", an, seg, dp, frame_tick);
        end
        for (int k = 0; k < 3; k++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({an, seg, dp, frame_tick} !== 13'b1110_1000000_1_0) begin
            failures++;
            $display("FAIL reset_mid_release got %b_%b_%b_%b want 1110_1000000_1_0", an, seg, dp, frame_tick);
        end
        @(negedge clk);
        wait_phase(1);
        for (int k = 0; k < 16; k++) begin
            e = exp_out(16'h0000, 4'b0000, cyc);
            checks++;
            if ({an, seg, dp, frame_tick} !== e) begin
                failures++;
                $display("FAIL reset_mid_lost n=%0d got %b_%b_%b_%b want %b", cyc, an, seg, dp, frame_tick, e);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan();
        test_no_tearing();
        test_back_to_back();
        test_coincident();
        test_invalid();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Four-digit multiplexed seven-segment driver for the Basys 3 display. It consumes the packed BCD digits produced by the counter blocks and time-multiplexes them onto the shared, active-low segment and anode lines at a fixed refresh rate. Digits are double-buffered, so a new value is only shown from the start of a scan frame and never tears mid-frame.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit (1 ms at 100 MHz, 250 Hz frame); legal range ≥ 2.
- `clock_100Mhz`  in  1  100 MHz system clock, W5 pin.
- `reset`  in  1  asynchronous, active-low reset.
- `digits_in`  in  16  four BCD digits; [3:0] is the rightmost digit (digit 0), [15:12] is the leftmost (digit 3).
- `dp_in`  in  4  decimal point request per digit, active-high; bit i belongs to digit i.
- `load`  in  1  single-cycle strobe that captures `digits_in` and `dp_in`.
- `an`  out  4  anode enables, active-low, one-hot-low while scanning.
- `seg`  out  7  cathodes {g,f,e,d,c,b,a}, active-low; `seg[0]` is segment a.
- `dp`  out  1  decimal point cathode, active-low.
- `frame_tick`  out  1  one-cycle pulse when the scan wraps from digit 3 back to digit 0.

## Operation
- **Prescaler.**
  - Counts 0 to `REFRESH_DIV-1`, then wraps to 0.
  - The wrap cycle is the *step* event.
- **Digit index.**
  - 2-bit counter that increments on each step: 0 → 1 → 2 → 3 → 0.
  - A step taken while the index is 3 is the *frame boundary*.
- **Buffering.**
  - `load` writes `digits_in` and `dp_in` into the pending register.
  - At a frame boundary, the pending register is copied into the display register.
  - If `load` and a frame boundary occur in the same cycle, the display register takes `digits_in`/`dp_in` directly, and pending is also updated.
  - Repeated loads within one frame: the last one wins.
- **Decode** (display-register nibble → `seg`):
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - Any non-BCD nibble (A–F) shows a dash: 0111111.
- **Output drive.**
  - `an` = ~(1 << index).
  - `dp` = ~dp_bit[index].
- **Registering.** All outputs are registered, so they reflect the index and display register from the previous cycle.

## Timing
- **Reset values** (asynchronous, while `reset` = 0):
  - prescaler 0, index 0, pending and display registers 0
  - `an` = 1111, `seg` = 1111111, `dp` = 1, `frame_tick` = 0
- **After reset release.**
  - First rising edge: `an` = 1110 and `seg` = 1000000 (digit 0 shows "0").
  - Digit i is driven for exactly `REFRESH_DIV` cycles.
  - The full frame is 4·`REFRESH_DIV` cycles.
- **Index change to output.** `an`/`seg` change one cycle after the step cycle.
- **`frame_tick`.** Asserted in the cycle after the frame-boundary step, coincident with `an` returning to 1110.
- **Load to display.**
  - New digits first appear on `an` = 1110 in the frame that starts after the next boundary.
  - Worst case latency: 4·`REFRESH_DIV` + 1 cycles.
- **Reset mid-frame.** Aborts immediately; blank outputs; the scan restarts at digit 0; the pending value is lost.

## Configuration
- **Macro:** `SEVSEG_LZ_BLANK_EN`.
- **Defined:** leading-zero blanking.
  - Digit 3 is blanked if it is 0.
  - Digit 2 is blanked if digits 3 and 2 are 0.
  - Digit 1 is blanked if digits 3, 2 and 1 are 0.
  - Digit 0 is never blanked.
  - A blanked digit drives `seg` = 1111111, but its anode still scans and `dp` still follows `dp_in`.
  - Non-BCD nibbles count as non-zero.
- **Undefined:** every digit is always decoded; zeros show 1000000.

## Test plan
All scenarios use `REFRESH_DIV` = 4.
- **Reset.** Hold `reset` = 0 for 10 cycles → `an` = 1111, `seg` = 1111111, `dp` = 1, `frame_tick` = 0 throughout. Release → `an` = 1110 next edge.
- **Scan and decode.** Load `digits_in` = 16'h1234, `dp_in` = 4'b0100, then wait one boundary.
  - Sequence: `an` 1110 / `seg` 0011001 (4), then 1101 / 0110000 (3), then 1011 / 0100100 (2) with `dp` = 0, then 0111 / 1111001 (1).
  - Each step lasts 4 cycles, and `frame_tick` pulses once per 16 cycles.
- **No tearing.** Load 16'h5678 while the index is 1 → digits 2 and 3 keep showing the old value until the boundary. Two loads (h1111 then h2222) in the same frame → only h2222 is displayed.
- **Coincident load and boundary.** Assert `load` with 16'h9999 in the exact boundary cycle → the next frame shows 9 on all digits (`seg` = 0010000).
- **Invalid nibble and blanking.** Load 16'h00A0.
  - Digit 1 shows 0111111 (dash).
  - With `SEVSEG_LZ_BLANK_EN`: digits 3 and 2 show 1111111, digit 0 shows 1000000.
  - Without it: digits 3 and 2 show 1000000.
- **Reset mid-operation.** Assert `reset` while the index is 2 with 16'h1234 displayed → outputs blank immediately. After release, digit 0 shows "0" (display register cleared).
